// File: rtl/usb3_pkt_pkg.sv
// Shared USB3 packet definitions: header marker, type codes, header layout and FSM encoding.
// Used by the transmit framer and the receive cache parser.
package usb3_pkt_pkg;

  localparam logic [31:0] HDR_MARK    = 32'hFF0000FF;
  localparam logic [15:0] TYPE_CODE_1 = 16'h0000;
  localparam logic [15:0] TYPE_CODE_2 = 16'h000A;
  localparam logic [15:0] TYPE_CODE_3 = 16'h0AAA;
  localparam logic [15:0] TYPE_CODE_4 = 16'hAAAA;
  localparam logic [15:0] TYPE_CODE_5 = 16'h00AA;

  typedef struct packed {
    logic [7:0]  mark_hi;
    logic [15:0] code;
    logic [7:0]  mark_lo;
  } usb3_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TRAILER = 3'd3,
    ST_END     = 3'd4,
    ST_GAP     = 3'd5
  } pkt_state_e;

  function automatic logic type_valid(input logic [2:0] pack_type);
    return (pack_type >= 3'd1) && (pack_type <= 3'd5);
  endfunction

  function automatic logic [15:0] type_code(input logic [2:0] pack_type);
    case (pack_type)
      3'd1:    return TYPE_CODE_1;
      3'd2:    return TYPE_CODE_2;
      3'd3:    return TYPE_CODE_3;
      3'd4:    return TYPE_CODE_4;
      3'd5:    return TYPE_CODE_5;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] hdr_word(input logic [15:0] code);
    usb3_hdr_t h;
    h      = usb3_hdr_t'(HDR_MARK);
    h.code = code;
    return h;
  endfunction

endpackage

// File: rtl/usb3_tx_skid.sv
// Two-entry skid with bypass: absorbs the cache RAM read latency and FX3 full-flag stalls.
// in_ready_c means a read issued this cycle (landing next cycle) is guaranteed a slot.
module usb3_tx_skid #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              wrclock,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready_c,
  output logic              out_valid_c,
  output logic [DATA_W-1:0] out_data_c,
  input  logic              out_ready
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              empty_c;
  logic              pop_c;
  logic              store_c;
  logic              deq_c;
  logic [1:0]        count_nxt_c;

  // Empty skid passes the RAM word straight through so the payload stays gapless
  assign empty_c     = (count == 2'd0);
  assign out_valid_c = !empty_c || in_valid;
  assign out_data_c  = empty_c ? in_data : mem[rd_ptr];
  assign pop_c       = out_valid_c && out_ready;
  assign store_c     = in_valid && !(empty_c && pop_c);
  assign deq_c       = pop_c && !empty_c;
  assign count_nxt_c = count + 2'(store_c) - 2'(deq_c);
  assign in_ready_c  = (count_nxt_c < 2'd2);

  always_ff @(posedge wrclock or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store_c) wr_ptr <= !wr_ptr;
      if (deq_c)   rd_ptr <= !rd_ptr;
      count <= count_nxt_c;
    end
  end

  always_ff @(posedge wrclock) begin
    if (store_c) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/usb3_pkt_tx.sv
// FX3 slave-FIFO packet framer: header word, PKT_WORDS cache words, then PKTEND.
// Optional checksum trailer word enabled by USB3_TX_CSUM_EN.
module usb3_pkt_tx
  import usb3_pkt_pkg::*;
#(
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              wrclock,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        pack_type,
  output logic [ADDR_W-1:0] src_rdaddress,
  input  logic [31:0]       src_q,
  output logic [31:0]       USB3_DATA,
  output logic              USB3_SLWR_N,
  output logic              USB3_PKTEND_N,
  input  logic              USB3_FLAGB,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  N_WORDS   = CNT_W'(PKT_WORDS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(PKT_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PKT_WORDS - 1);

  pkt_state_e        state, state_nxt;
  logic              flagb_q;
  logic              rd_pend;
  logic [15:0]       hdr_code, code_nxt;
  logic [CNT_W-1:0]  fetch_cnt, fetch_nxt;
  logic [CNT_W-1:0]  wr_cnt, wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       data_nxt;
  logic              slwr_n_nxt, pktend_n_nxt, busy_nxt, done_nxt, err_nxt;
  logic              issue_c, skid_ready_c, skid_valid_c, skid_out_ready_c;
  logic [31:0]       skid_data_c;
`ifdef USB3_TX_CSUM_EN
  logic [31:0]       csum, csum_nxt;
`endif

  // Reads are issued only when the skid can take the word one cycle later
  assign issue_c = ((state == ST_HDR) || (state == ST_PAYLOAD)) &&
                   (fetch_cnt != N_WORDS) && skid_ready_c;
  assign skid_out_ready_c = (state == ST_PAYLOAD) && flagb_q;

  usb3_tx_skid #(.DATA_W(32)) u_skid (
    .wrclock     (wrclock),
    .rst         (rst),
    .in_valid    (rd_pend),
    .in_data     (src_q),
    .in_ready_c  (skid_ready_c),
    .out_valid_c (skid_valid_c),
    .out_data_c  (skid_data_c),
    .out_ready   (skid_out_ready_c)
  );

  always_ff @(posedge wrclock or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    code_nxt     = hdr_code;
    addr_nxt     = src_rdaddress;
    fetch_nxt    = fetch_cnt;
    wr_nxt       = wr_cnt;
    data_nxt     = USB3_DATA;
    slwr_n_nxt   = 1'b1;
    pktend_n_nxt = 1'b1;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
`ifdef USB3_TX_CSUM_EN
    csum_nxt     = csum;
`endif
    if (issue_c) begin
      fetch_nxt = fetch_cnt + CNT_W'(1);
      if (src_rdaddress != LAST_ADDR) addr_nxt = src_rdaddress + ADDR_W'(1);
    end
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (type_valid(pack_type)) begin
            code_nxt  = type_code(pack_type);
            addr_nxt  = '0;
            fetch_nxt = '0;
            wr_nxt    = '0;
            busy_nxt  = 1'b1;
            state_nxt = ST_HDR;
`ifdef USB3_TX_CSUM_EN
            csum_nxt  = '0;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (flagb_q) begin
          data_nxt   = hdr_word(hdr_code);
          slwr_n_nxt = 1'b0;
          state_nxt  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (skid_valid_c && flagb_q) begin
          data_nxt   = skid_data_c;
          slwr_n_nxt = 1'b0;
          wr_nxt     = wr_cnt + CNT_W'(1);
`ifdef USB3_TX_CSUM_EN
          csum_nxt   = csum + skid_data_c;
          if (wr_cnt == LAST_IDX) state_nxt = ST_TRAILER;
`else
          if (wr_cnt == LAST_IDX) state_nxt = ST_END;
`endif
        end
      end
`ifdef USB3_TX_CSUM_EN
      ST_TRAILER: begin
        if (flagb_q) begin
          data_nxt   = csum;
          slwr_n_nxt = 1'b0;
          state_nxt  = ST_END;
        end
      end
`endif
      ST_END: begin
        pktend_n_nxt = 1'b0;
        state_nxt    = ST_GAP;
      end
      ST_GAP: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wrclock or posedge rst) begin
    if (rst) begin
      flagb_q       <= 1'b0;
      rd_pend       <= 1'b0;
      hdr_code      <= '0;
      fetch_cnt     <= '0;
      wr_cnt        <= '0;
      src_rdaddress <= '0;
      USB3_DATA     <= '0;
      USB3_SLWR_N   <= 1'b1;
      USB3_PKTEND_N <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      flagb_q       <= USB3_FLAGB;
      rd_pend       <= issue_c;
      hdr_code      <= code_nxt;
      fetch_cnt     <= fetch_nxt;
      wr_cnt        <= wr_nxt;
      src_rdaddress <= addr_nxt;
      USB3_DATA     <= data_nxt;
      USB3_SLWR_N   <= slwr_n_nxt;
      USB3_PKTEND_N <= pktend_n_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
    end
  end

`ifdef USB3_TX_CSUM_EN
  always_ff @(posedge wrclock or posedge rst) begin
    if (rst) csum <= '0;
    else     csum <= csum_nxt;
  end
`endif

endmodule
